// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-style multiply/divide unit.
package mips_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned MULDIV_STEPS = 32;
    localparam int unsigned CNT_W        = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on sign-stripped operands.
module mul_div_unit
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned PR_W = 2 * DATA_W;

    muldiv_state_t      state_q, nxt_state;
    logic [CNT_W-1:0]   count_q, nxt_count;
    logic [PR_W-1:0]    pr_q, nxt_pr;
    logic [DATA_W-1:0]  dvs_q, nxt_dvs;
    muldiv_op_t         op_q, nxt_op;
    logic               neg_q, nxt_neg;
    logic               rem_neg_q, nxt_rem_neg;
    logic               zero_q, nxt_zero;
    logic [DATA_W-1:0]  nxt_hi, nxt_lo;
    logic               nxt_busy, nxt_done, nxt_dbz;

    muldiv_op_t         op_in;
    logic               sgn_in;
    logic [DATA_W-1:0]  a_mag, b_mag;
    logic [DATA_W:0]    mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [PR_W-1:0]    prod_fix;
    logic [DATA_W-1:0]  quo_fix, rem_fix;

    // Shared 33-bit step arithmetic: pr_q holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        op_in     = muldiv_op_t'(op);
        sgn_in    = is_signed_op(op_in);
        a_mag     = (sgn_in && A[DATA_W-1]) ? DATA_W'(-A) : A;
        b_mag     = (sgn_in && B[DATA_W-1]) ? DATA_W'(-B) : B;
        mul_sum   = {1'b0, pr_q[PR_W-1:DATA_W]} + {1'b0, dvs_q};
        div_trial = {pr_q[PR_W-1:DATA_W], pr_q[DATA_W-1]};
        div_diff  = div_trial - {1'b0, dvs_q};
        // A set top bit means the trial already exceeds any 32-bit divisor
        div_ge    = div_trial[DATA_W] | ~div_diff[DATA_W];
        prod_fix  = neg_q ? PR_W'(-pr_q) : pr_q;
        quo_fix   = neg_q ? DATA_W'(-pr_q[DATA_W-1:0]) : pr_q[DATA_W-1:0];
        rem_fix   = rem_neg_q ? DATA_W'(-pr_q[PR_W-1:DATA_W]) : pr_q[PR_W-1:DATA_W];
    end

    // Next-state and datapath
    always_comb begin
        nxt_state   = state_q;
        nxt_count   = count_q;
        nxt_pr      = pr_q;
        nxt_dvs     = dvs_q;
        nxt_op      = op_q;
        nxt_neg     = neg_q;
        nxt_rem_neg = rem_neg_q;
        nxt_zero    = zero_q;
        nxt_hi      = hi;
        nxt_lo      = lo;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                nxt_state = ST_IDLE;
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            nxt_state   = ST_CALC;
                            nxt_count   = '0;
                            nxt_pr      = {{DATA_W{1'b0}}, a_mag};
                            nxt_dvs     = b_mag;
                            nxt_op      = op_in;
                            nxt_neg     = sgn_in & (A[DATA_W-1] ^ B[DATA_W-1]);
                            nxt_rem_neg = sgn_in & A[DATA_W-1];
                            nxt_zero    = is_div_op(op_in) && (B == '0);
                        end
                        OP_MTHI: nxt_hi = A;
                        OP_MTLO: nxt_lo = A;
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (count_q == CNT_W'(MULDIV_STEPS)) begin
                    nxt_state = ST_FIXUP;
                end else begin
                    nxt_count = count_q + CNT_W'(1);
                    if (is_div_op(op_q)) begin
                        nxt_pr = div_ge ? {div_diff[DATA_W-1:0], pr_q[DATA_W-2:0], 1'b1}
                                        : {div_trial[DATA_W-1:0], pr_q[DATA_W-2:0], 1'b0};
                    end else begin
                        nxt_pr = pr_q[0] ? {mul_sum, pr_q[DATA_W-1:1]}
                                         : {1'b0, pr_q[PR_W-1:1]};
                    end
                end
            end
            ST_FIXUP: begin
                nxt_state = ST_DONE;
                if (is_div_op(op_q)) begin
                    // Divide by zero leaves the remainder equal to A after sign fix
                    nxt_hi = rem_fix;
                    nxt_lo = zero_q ? {DATA_W{1'b1}} : quo_fix;
                end else begin
                    nxt_hi = prod_fix[PR_W-1:DATA_W];
                    nxt_lo = prod_fix[DATA_W-1:0];
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        nxt_busy = (nxt_state == ST_CALC) || (nxt_state == ST_FIXUP);
        nxt_done = (nxt_state == ST_DONE);
        nxt_dbz  = nxt_done && zero_q;
    end

    // All state, including the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pr_q        <= '0;
            dvs_q       <= '0;
            op_q        <= OP_MULT;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            count_q     <= nxt_count;
            pr_q        <= nxt_pr;
            dvs_q       <= nxt_dvs;
            op_q        <= nxt_op;
            neg_q       <= nxt_neg;
            rem_neg_q   <= nxt_rem_neg;
            zero_q      <= nxt_zero;
            hi          <= nxt_hi;
            lo          <= nxt_lo;
            busy        <= nxt_busy;
            done        <= nxt_done;
            div_by_zero <= nxt_dbz;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, results, flags, ignore rules, reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Present a request for one edge, then scramble the operands
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    endtask

    // Edges counted after the sampling edge until done rises; 100 means timeout
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0;
        @(posedge clk); #1;
        n_cmp++; if (hi !== 32'h0)       begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0)       begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multiply();
        logic [2:0]  t_op [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
        logic [31:0] t_a  [5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
        logic [31:0] t_b  [5] = '{32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'h00000002, 32'h00000010};
        logic [31:0] t_hi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
        logic [31:0] t_lo [5] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000001, 32'h00000000, 32'h23456780};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul%0d_busy: got %b want 1", i, busy); end
            wait_done(cyc);
            n_cmp++; if (cyc !== 34)     begin n_err++; $display("FAIL mul%0d_latency: got %0d want 34", i, cyc); end
            n_cmp++; if (hi !== t_hi[i]) begin n_err++; $display("FAIL mul%0d_hi: got %h want %h", i, hi, t_hi[i]); end
            n_cmp++; if (lo !== t_lo[i]) begin n_err++; $display("FAIL mul%0d_lo: got %h want %h", i, lo, t_lo[i]); end
            n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL mul%0d_dbz: got %b want 0", i, div_by_zero); end
            n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mul%0d_busy_done: got %b want 0", i, busy); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL mul%0d_pulse: got %b want 0", i, done); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  t_op [6] = '{3'b010, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010};
        logic [31:0] t_a  [6] = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF8};
        logic [31:0] t_b  [6] = '{32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        logic [31:0] t_lo [6] = '{32'hFFFFFFFD, 32'h80000000, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
        logic [31:0] t_hi [6] = '{32'hFFFFFFFF, 32'h00000000, 32'd2, 32'd1, 32'd0, 32'hFFFFFFFE};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            wait_done(cyc);
            n_cmp++; if (cyc !== 34)     begin n_err++; $display("FAIL div%0d_latency: got %0d want 34", i, cyc); end
            n_cmp++; if (lo !== t_lo[i]) begin n_err++; $display("FAIL div%0d_lo: got %h want %h", i, lo, t_lo[i]); end
            n_cmp++; if (hi !== t_hi[i]) begin n_err++; $display("FAIL div%0d_hi: got %h want %h", i, hi, t_hi[i]); end
            n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div%0d_dbz: got %b want 0", i, div_by_zero); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(3'b011, 32'd100, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc !== 34)          begin n_err++; $display("FAIL dbz_latency: got %0d want 34", cyc); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        n_cmp++; if (hi !== 32'd100)      begin n_err++; $display("FAIL dbz_hi: got %h want 64", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dbz_lo: got %h want ffffffff", lo); end
        // Accepted in the DONE cycle with no idle gap
        launch(3'b011, 32'd100, 32'd7);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got done=%b busy=%b want 0/1", done, busy); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL b2b_dbz_clear: got %b want 0", div_by_zero); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 34)     begin n_err++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
        n_cmp++; if (lo !== 32'd14)  begin n_err++; $display("FAIL b2b_lo: got %h want e", lo); end
        n_cmp++; if (hi !== 32'd2)   begin n_err++; $display("FAIL b2b_hi: got %h want 2", hi); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL b2b_dbz: got %b want 0", div_by_zero); end
        launch(3'b010, 32'hFFFFFFFB, 32'd0);
        wait_done(cyc);
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL sdbz_flag: got %b want 1", div_by_zero); end
        n_cmp++; if (hi !== 32'hFFFFFFFB) begin n_err++; $display("FAIL sdbz_hi: got %h want fffffffb", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sdbz_lo: got %h want ffffffff", lo); end
        @(posedge clk); #1;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL sdbz_pulse: got %b want 0", div_by_zero); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        launch(3'b101, 32'h0000AAAA, 32'h0);
        n_cmp++; if (lo !== 32'h0000AAAA) begin n_err++; $display("FAIL mtlo_lo: got %h want aaaa", lo); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mtlo_flags: got busy=%b done=%b want 0/0", busy, done); end
        launch(3'b001, 32'd3, 32'd4);
        cyc = 0;
        while (cyc < 100) begin
            if (cyc == 9) begin start = 1'b1; op = 3'b101; A = 32'd5; B = 32'd9; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) begin
                n_cmp++; if (lo !== 32'h0000AAAA) begin n_err++; $display("FAIL calc_lo_hold: got %h want aaaa", lo); end
            end
            if (done) break;
        end
        start = 1'b0;
        n_cmp++; if (cyc !== 34)   begin n_err++; $display("FAIL ignore_latency: got %0d want 34", cyc); end
        n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL ignore_lo: got %h want c", lo); end
        n_cmp++; if (hi !== 32'd0)  begin n_err++; $display("FAIL ignore_hi: got %h want 0", hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        launch(3'b010, 32'd1000, 32'd3);
        repeat (19) begin @(posedge clk); #1; end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL mid_clear: got hi=%h lo=%h want 0/0", hi, lo); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_flags: got busy=%b done=%b want 0/0", busy, done); end
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 3'b100; A = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_after_reset: got %h want 1234", hi); end
        n_cmp++; if (lo !== 32'h0)    begin n_err++; $display("FAIL mthi_lo: got %h want 0", lo); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_reserved();
        launch(3'b110, 32'h5555, 32'h1);
        n_cmp++; if (hi !== 32'h1234 || lo !== 32'h0) begin n_err++; $display("FAIL rsv6_hold: got hi=%h lo=%h want 1234/0", hi, lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rsv6_busy: got %b want 0", busy); end
        launch(3'b111, 32'h6666, 32'h2);
        n_cmp++; if (hi !== 32'h1234 || lo !== 32'h0) begin n_err++; $display("FAIL rsv7_hold: got hi=%h lo=%h want 1234/0", hi, lo); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rsv_flags: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_reserved();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-002 start  input  1  request; sampled on rising clk.
REQ-003 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect).
REQ-004 A, B  input  32 each  operands (A = multiplicand or dividend; B = multiplier or divisor; MTHI/MTLO use A).
REQ-005 busy  output  1  iterative operation in progress.
REQ-006 done  output  1  one-cycle pulse; hi/lo valid.
REQ-007 div_by_zero  output  1  qualifies done; set for DIV/DIVU with B == 0.
REQ-008 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-009 States SHALL be IDLE, CALC, FIXUP and DONE; encoding is free.
REQ-010 IDLE or DONE with start=1 and op in {000..011}: latch A, B and op, then go to CALC with count=0.
REQ-011 IDLE or DONE with start=1 and op=100 or 101: write A to hi (100) or lo (101) at that edge; next state IDLE; no done pulse.
REQ-012 Reserved op, or start=0: next state from IDLE and DONE is IDLE; hi and lo are unchanged.
REQ-013 Signed ops: magnitudes SHALL be formed at latch time; unsigned ops use raw operands.
REQ-014 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; count increments; after the 32nd step go to FIXUP.
REQ-015 FIXUP: apply the sign and write hi/lo at the edge leaving FIXUP; next state DONE.
REQ-016 Multiply results: {hi,lo} = 64-bit product, two's complement for MULT.
REQ-017 Divide results: lo = quotient, hi = remainder.
REQ-018 Signed divide: quotient is negative iff the operand signs differ; remainder sign follows the dividend.
REQ-019 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0, with no flag.
REQ-020 Divide with B == 0: hi=A, lo=32'hFFFFFFFF, and div_by_zero=1 in the DONE cycle; applies to DIV and DIVU.
REQ-021 done SHALL be 1 only in DONE, i.e. exactly 34 cycles after the edge that sampled start; hi and lo already hold the result in that cycle.
REQ-022 busy SHALL be 1 in CALC and FIXUP, 0 in IDLE and DONE.
REQ-023 start while busy=1 SHALL be ignored, including MTHI/MTLO; in-flight operands are unaffected by changes on A and B.
REQ-024 hi and lo SHALL be unchanged during CALC; only FIXUP, MTHI or MTLO write them.
REQ-025 Back-to-back: start accepted in the DONE cycle begins a new operation with no idle cycle.

Reset
REQ-026 On reset assertion, asynchronously: state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-027 Reset mid-operation SHALL abandon the operation, emit no done pulse, and clear hi/lo.
REQ-028 Reset deassertion is synchronous to clk; the first start is accepted at the first edge after deassertion.

Structure
REQ-029 Shared package mips_pkg SHALL hold the muldiv_op_t enum (3-bit), the state enum, and MULDIV_STEPS=32.
REQ-030 The block SHALL be a single module with no sub-module; the 33-bit add/subtract is inline.
REQ-031 All state SHALL use one always_ff with asynchronous reset; next-state logic and the datapath SHALL be in always_comb.

Verification
REQ-032 MULTU, A=32'hFFFFFFFF, B=32'hFFFFFFFF -> done at cycle 34; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-033 MULT, A=-7, B=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV, A=-7, B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-034 DIVU, A=100, B=0 -> done with div_by_zero=1, hi=100, lo=32'hFFFFFFFF; the next DIVU 100/7 -> div_by_zero=0, lo=14, hi=2.
REQ-035 MULTU started, then start with MTLO A=5 at cycle 10 -> MTLO ignored; lo equals the product at done.
REQ-036 Reset asserted at cycle 20 of a DIV -> hi=lo=0, no done pulse; MTHI A=32'h1234 at the next edge -> hi=32'h1234 one edge later.
REQ-037 DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0, div_by_zero=0.
